// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and defaults for the parking keypad entry block
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIGIT2  = 2'd1,
        ST_PRESENT = 2'd2
    } entry_state_t;

    localparam int DIGIT_W_DEF = 2;

endpackage

// File: rtl/parking_keypad_entry_if.sv
// rtl/parking_keypad_entry_if.sv - keypad inputs and password handshake bundle
interface parking_keypad_entry_if
    import parking_pkg::*;
#(
    parameter int DIGIT_W = DIGIT_W_DEF
);
    logic               key_press;
    logic [DIGIT_W-1:0] key_code;
    logic               key_clear;
    logic               pass_ack;
    logic [DIGIT_W-1:0] password_1;
    logic [DIGIT_W-1:0] password_2;
    logic               pass_valid;
    logic [1:0]         digit_count;
    logic               timeout_err;

    // keypad pins and password consumer
    modport master (
        output key_press, key_code, key_clear, pass_ack,
        input  password_1, password_2, pass_valid, digit_count, timeout_err
    );

    // entry block
    modport slave (
        input  key_press, key_code, key_clear, pass_ack,
        output password_1, password_2, pass_valid, digit_count, timeout_err
    );
endinterface

// File: rtl/parking_debounce.sv
// rtl/parking_debounce.sv - 2-FF synchroniser plus stability counter with rise strobe
module parking_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // synchronise, then flip level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            cnt        <= '0;
            level      <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            rise_pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level      <= sync2;
                cnt        <= '0;
                rise_pulse <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/parking_keypad_entry.sv
// rtl/parking_keypad_entry.sv - two-digit keypad collector with valid/ack password handoff
module parking_keypad_entry
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 200,
    parameter int DIGIT_W         = DIGIT_W_DEF
) (
    input logic                   clk,
    input logic                   reset,
    parking_keypad_entry_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic               key_level;
    logic               press;
    logic [DIGIT_W-1:0] code_s1;
    logic [DIGIT_W-1:0] code_s2;

    entry_state_t       state;
    logic [TW-1:0]      timer;
    logic [DIGIT_W-1:0] pw1;
    logic [DIGIT_W-1:0] pw2;
    logic               valid_q;
    logic [1:0]         count_q;
    logic               timeout_q;

    parking_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .raw       (bus.key_press),
        .level     (key_level),
        .rise_pulse(press)
    );

    // key_code follows the same 2-FF path; it is long settled when the rise strobe fires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_s1 <= '0;
            code_s2 <= '0;
        end else begin
            code_s1 <= bus.key_code;
            code_s2 <= code_s1;
        end
    end

    // entry FSM with DIGIT2 inter-digit timer and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            timer     <= '0;
            pw1       <= '0;
            pw2       <= '0;
            valid_q   <= 1'b0;
            count_q   <= 2'd0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (press) begin
                        pw1     <= code_s2;
                        pw2     <= '0;
                        timer   <= '0;
                        state   <= ST_DIGIT2;
                        count_q <= 2'd1;
                    end
                end
                ST_DIGIT2: begin
                    if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                    if (press) begin
                        pw2     <= code_s2;
                        state   <= ST_PRESENT;
                        valid_q <= 1'b1;
                        count_q <= 2'd2;
                    end else if (bus.key_clear) begin
                        state   <= ST_IDLE;
                        count_q <= 2'd0;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_q <= 1'b1;
                        state     <= ST_IDLE;
                        count_q   <= 2'd0;
                    end
                end
                ST_PRESENT: begin
                    if (bus.pass_ack || bus.key_clear) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                        count_q <= 2'd0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                    count_q <= 2'd0;
                end
            endcase
        end
    end

    assign bus.password_1  = pw1;
    assign bus.password_2  = pw2;
    assign bus.pass_valid  = valid_q;
    assign bus.digit_count = count_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_parking_keypad_entry.sv
// tb/tb_parking_keypad_entry.sv - directed self-checking bench for parking_keypad_entry
module tb_parking_keypad_entry;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   to_pulses;
    int   pv_cycles;

    parking_keypad_entry_if #(.DIGIT_W(2)) bus ();

    parking_keypad_entry #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (50),
        .DIGIT_W        (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (bus.timeout_err === 1'b1) to_pulses++;
        if (bus.pass_valid === 1'b1) pv_cycles++;
    end

    task automatic press(input logic [1:0] code, input int hold);
        bus.key_code  = code;
        bus.key_press = 1'b1;
        repeat (hold) @(negedge clk);
        bus.key_press = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_digit1(input string tag);
        int n;
        n = 0;
        while (bus.digit_count !== 2'd1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.digit_count !== 2'd1) begin
            errors++;
            $display("FAIL %s_wait: digit_count=%0d expected 1 within 20 cycles", tag, bus.digit_count);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.password_1, bus.password_2, bus.pass_valid, bus.digit_count, bus.timeout_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got p1=%0d p2=%0d pv=%0d dc=%0d to=%0d expected all 0",
                     bus.password_1, bus.password_2, bus.pass_valid, bus.digit_count, bus.timeout_err);
        end
        reset = 1'b0;
        @(negedge clk);
        bus.key_clear = 1'b1;
        @(negedge clk);
        bus.key_clear = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.digit_count !== 2'd0 || bus.pass_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_clear: dc=%0d pv=%0d expected 0 0", bus.digit_count, bus.pass_valid);
        end
    endtask

    task automatic test_happy;
        press(2'd1, 10);
        press(2'd2, 10);
        checks++;
        if (bus.pass_valid !== 1'b1) begin
            errors++;
            $display("FAIL happy_valid: got %0d expected 1", bus.pass_valid);
        end
        checks++;
        if (bus.password_1 !== 2'd1 || bus.password_2 !== 2'd2) begin
            errors++;
            $display("FAIL happy_pw: got %0d/%0d expected 1/2", bus.password_1, bus.password_2);
        end
        checks++;
        if (bus.digit_count !== 2'd2) begin
            errors++;
            $display("FAIL happy_count: got %0d expected 2", bus.digit_count);
        end
        bus.pass_ack = 1'b1;
        @(negedge clk);
        bus.pass_ack = 1'b0;
        checks++;
        if (bus.pass_valid !== 1'b0 || bus.digit_count !== 2'd0) begin
            errors++;
            $display("FAIL happy_ack: pv=%0d dc=%0d expected 0 0", bus.pass_valid, bus.digit_count);
        end
        checks++;
        if (bus.password_1 !== 2'd1 || bus.password_2 !== 2'd2) begin
            errors++;
            $display("FAIL happy_hold: got %0d/%0d expected 1/2", bus.password_1, bus.password_2);
        end
    endtask

    task automatic test_bounce;
        int lens[3] = '{1, 2, 3};
        int to_before;
        bus.key_code = 2'd3;
        foreach (lens[i]) begin
            bus.key_press = 1'b1;
            repeat (lens[i]) @(negedge clk);
            bus.key_press = 1'b0;
            @(negedge clk);
        end
        bus.key_press = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.digit_count !== 2'd0) begin
            errors++;
            $display("FAIL bounce_early: dc=%0d expected 0 at 6 cycles", bus.digit_count);
        end
        @(negedge clk);
        checks++;
        if (bus.digit_count !== 2'd1 || bus.password_1 !== 2'd3) begin
            errors++;
            $display("FAIL bounce_latency: dc=%0d p1=%0d expected 1 3 at 7 cycles", bus.digit_count, bus.password_1);
        end
        repeat (3) @(negedge clk);
        bus.key_press = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (bus.digit_count !== 2'd1) begin
            errors++;
            $display("FAIL bounce_single: dc=%0d expected 1", bus.digit_count);
        end
        to_before = to_pulses;
        bus.key_clear = 1'b1;
        @(negedge clk);
        bus.key_clear = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.digit_count !== 2'd0 || to_pulses != to_before) begin
            errors++;
            $display("FAIL clear_digit2: dc=%0d timeouts=%0d expected 0 0", bus.digit_count, to_pulses - to_before);
        end
        checks++;
        if (bus.password_1 !== 2'd3) begin
            errors++;
            $display("FAIL clear_hold_p1: got %0d expected 3", bus.password_1);
        end
    endtask

    task automatic test_timeout;
        int to_before;
        int pv_before;
        int n;
        to_before = to_pulses;
        pv_before = pv_cycles;
        bus.key_code  = 2'd1;
        bus.key_press = 1'b1;
        wait_digit1("timeout");
        bus.key_press = 1'b0;
        n = 0;
        while (bus.timeout_err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 50) begin
            errors++;
            $display("FAIL timeout_latency: pulse after %0d cycles expected 50", n);
        end
        @(negedge clk);
        checks++;
        if (bus.timeout_err !== 1'b0 || to_pulses - to_before != 1) begin
            errors++;
            $display("FAIL timeout_pulse: to=%0d pulses=%0d expected 0 1", bus.timeout_err, to_pulses - to_before);
        end
        checks++;
        if (bus.digit_count !== 2'd0 || pv_cycles != pv_before) begin
            errors++;
            $display("FAIL timeout_idle: dc=%0d pv_cycles=%0d expected 0 0", bus.digit_count, pv_cycles - pv_before);
        end
    endtask

    task automatic test_collision;
        int to_before;
        to_before = to_pulses;
        bus.key_code  = 2'd2;
        bus.key_press = 1'b1;
        wait_digit1("collide");
        bus.key_press = 1'b0;
        repeat (43) @(negedge clk);
        bus.key_code  = 2'd1;
        bus.key_press = 1'b1;
        repeat (7) @(negedge clk);
        checks++;
        if (bus.digit_count !== 2'd2 || bus.pass_valid !== 1'b1) begin
            errors++;
            $display("FAIL collide_capture: dc=%0d pv=%0d expected 2 1", bus.digit_count, bus.pass_valid);
        end
        checks++;
        if (bus.password_1 !== 2'd2 || bus.password_2 !== 2'd1 || to_pulses != to_before) begin
            errors++;
            $display("FAIL collide_values: p1=%0d p2=%0d timeouts=%0d expected 2 1 0",
                     bus.password_1, bus.password_2, to_pulses - to_before);
        end
        bus.key_press = 1'b0;
        repeat (8) @(negedge clk);
        bus.pass_ack  = 1'b1;
        bus.key_clear = 1'b1;
        @(negedge clk);
        bus.pass_ack  = 1'b0;
        bus.key_clear = 1'b0;
        checks++;
        if (bus.digit_count !== 2'd0 || bus.pass_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_clear: dc=%0d pv=%0d expected 0 0", bus.digit_count, bus.pass_valid);
        end
    endtask

    task automatic test_reset_mid;
        press(2'd3, 10);
        press(2'd0, 10);
        checks++;
        if (bus.pass_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_present: pv=%0d expected 1", bus.pass_valid);
        end
        bus.key_code  = 2'd2;
        bus.key_press = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.pass_valid !== 1'b0 || bus.digit_count !== 2'd0 || bus.password_1 !== 2'd0) begin
            errors++;
            $display("FAIL mid_async: pv=%0d dc=%0d p1=%0d expected 0 0 0",
                     bus.pass_valid, bus.digit_count, bus.password_1);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (bus.digit_count !== 2'd0) begin
            errors++;
            $display("FAIL mid_early: dc=%0d expected 0 at 6 cycles", bus.digit_count);
        end
        @(negedge clk);
        checks++;
        if (bus.digit_count !== 2'd1 || bus.password_1 !== 2'd2) begin
            errors++;
            $display("FAIL mid_capture: dc=%0d p1=%0d expected 1 2", bus.digit_count, bus.password_1);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (bus.digit_count !== 2'd1) begin
            errors++;
            $display("FAIL mid_retrigger: dc=%0d expected 1", bus.digit_count);
        end
        bus.key_press = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        to_pulses     = 0;
        pv_cycles     = 0;
        reset         = 1'b1;
        bus.key_press = 1'b0;
        bus.key_code  = 2'd0;
        bus.key_clear = 1'b0;
        bus.pass_ack  = 1'b0;
        test_reset();
        test_happy();
        test_bounce();
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
